// File: rtl/mc_fifo_scfifo_pkg.sv
// Shared types and helpers for the single-clock memory-controller FIFO.
// Used by the top level and its sub-module.
package mc_fifo_pkg;

  typedef enum logic {
    RD_LEGACY    = 1'b0,
    RD_SHOWAHEAD = 1'b1
  } rd_mode_e;

  // Pointer width for a given depth; never below one bit.
  function automatic int addr_w(input int depth);
    if (depth <= 2) begin
      return 1;
    end else begin
      return $clog2(depth);
    end
  endfunction

  function automatic rd_mode_e rd_mode(input int showahead);
    if (showahead != 0) begin
      return RD_SHOWAHEAD;
    end else begin
      return RD_LEGACY;
    end
  endfunction

endpackage

// File: rtl/mc_fifo_scfifo_if.sv
// Write/read/status bundle between the MC front end and the RDMA engine.
// The FIFO is the slave; the producer/consumer side is the master.
interface mc_fifo_scfifo_if #(
  parameter int WIDTH = 60,
  parameter int DEPTH = 16
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] data;
  logic             wrreq;
  logic             rdreq;
  logic             clr_err;
  logic [WIDTH-1:0] q;
  logic             rdempty;
  logic             wrfull;
  logic             almost_full;
  logic [CW-1:0]    usedw;
  logic             ovf;
  logic             udf;

  modport slave (
    input  data, wrreq, rdreq, clr_err,
    output q, rdempty, wrfull, almost_full, usedw, ovf, udf
  );

  modport master (
    output data, wrreq, rdreq, clr_err,
    input  q, rdempty, wrfull, almost_full, usedw, ovf, udf
  );
endinterface

// File: rtl/mc_fifo_scfifo_ram.sv
// DEPTH x WIDTH storage: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset.
module mc_fifo_ram #(
  parameter int WIDTH = 60,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Write port.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/mc_fifo_scfifo.sv
// Single-clock FIFO: pointers, fill count, registered status flags,
// sticky overflow/underflow and the legacy-mode output register.
module mc_fifo_scfifo
  import mc_fifo_pkg::*;
#(
  parameter int WIDTH     = 60,
  parameter int DEPTH     = 16,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int SHOWAHEAD = 0
) (
  input  logic           clk,
  input  logic           aclr_n,
  mc_fifo_scfifo_if.slave bus
);

  localparam int       AW      = addr_w(DEPTH);
  localparam int       CW      = AW + 1;
  localparam rd_mode_e RD_MODE = rd_mode(SHOWAHEAD);

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             rdempty_q, rdempty_d, wrfull_q, wrfull_d, af_q, af_d;
  logic             ovf_q, ovf_d, udf_q, udf_d;
  logic [WIDTH-1:0] q_q, q_d, rd_data_s;
  logic             wr_acc_s, rd_acc_s;

  mc_fifo_ram #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk     (clk),
    .we_i    (wr_acc_s),
    .waddr_i (wr_ptr_q),
    .wdata_i (bus.data),
    .raddr_i (rd_ptr_q),
    .rdata_o (rd_data_s)
  );

  // Acceptance uses registered flags only: no pass-through when full, no fall-through when empty.
  always_comb begin
    wr_acc_s = bus.wrreq && !wrfull_q;
    rd_acc_s = bus.rdreq && !rdempty_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    q_d      = q_q;

    if (wr_acc_s) begin
      wr_ptr_d = wr_ptr_q + AW'(1'b1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (rd_acc_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1'b1);
      q_d      = rd_data_s;
    end else begin
      rd_ptr_d = rd_ptr_q;
      q_d      = q_q;
    end

    case ({wr_acc_s, rd_acc_s})
      2'b10:   cnt_d = cnt_q + CW'(1'b1);
      2'b01:   cnt_d = cnt_q - CW'(1'b1);
      default: cnt_d = cnt_q;
    endcase

    wrfull_d  = (cnt_d == CW'(DEPTH));
    rdempty_d = (cnt_d == CW'(1'b0));
    af_d      = (cnt_d >= CW'(AF_THRESH));

    // A fresh error beats a simultaneous clear.
    if (bus.wrreq && wrfull_q) begin
      ovf_d = 1'b1;
    end else if (bus.clr_err) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end

    if (bus.rdreq && rdempty_q) begin
      udf_d = 1'b1;
    end else if (bus.clr_err) begin
      udf_d = 1'b0;
    end else begin
      udf_d = udf_q;
    end
  end

  // State and status registers.
  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      rdempty_q <= 1'b1;
      wrfull_q  <= 1'b0;
      af_q      <= 1'b0;
      ovf_q     <= 1'b0;
      udf_q     <= 1'b0;
      q_q       <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      rdempty_q <= rdempty_d;
      wrfull_q  <= wrfull_d;
      af_q      <= af_d;
      ovf_q     <= ovf_d;
      udf_q     <= udf_d;
      q_q       <= q_d;
    end
  end

  assign bus.q           = (RD_MODE == RD_SHOWAHEAD) ? rd_data_s : q_q;
  assign bus.rdempty     = rdempty_q;
  assign bus.wrfull      = wrfull_q;
  assign bus.almost_full = af_q;
  assign bus.usedw       = cnt_q;
  assign bus.ovf         = ovf_q;
  assign bus.udf         = udf_q;

endmodule
